nec_fetch_queue: RTL and testbench
==================================

NEC_FETCH_QUEUE -- requirements
Module: nec_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8: queue capacity in bytes; power of two, 4..32.
REQ-002 Parameter FETCH_BYTES, default 2: bus fetch width in bytes; legal values 1 or 2.
REQ-003 Parameter WINDOW, default 6: bytes presented to the decoder; 3..DEPTH.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce_1, ce_2  in  1 each  clock enables; state advances only when ce_1|ce_2.
REQ-007 flush  in  1  discard queue contents and restart fetching at flush_pc.
REQ-008 flush_pc  in  16  new fetch and decode PC.
REQ-009 fetch_req  out  1  bus fetch request.
REQ-010 fetch_addr  out  16  byte address of the request.
REQ-011 fetch_ack  in  1  fetch complete; fetch_data valid.
REQ-012 fetch_data  in  8*FETCH_BYTES  fetched bytes; byte 0 = even address.
REQ-013 consume_len  in  clog2(WINDOW+1)  bytes retired by the decoder this enable cycle; 0 = none.
REQ-014 window  out  WINDOW x 8  window[i] = byte at pc+i; valid for i < avail.
REQ-015 avail  out  clog2(DEPTH+1)  valid bytes queued.
REQ-016 pc  out  16  address of window[0].

Function
REQ-017 Storage SHALL be a DEPTH-byte circular buffer with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-018 The fetch FSM SHALL have states IDLE, REQ and DISCARD.
REQ-019 IDLE -> REQ when free space (DEPTH-avail) >= bytes the next fetch delivers; fetch_req=1 exactly in REQ and DISCARD.
REQ-020 FETCH_BYTES=2 with even fetch_addr: a fetch delivers 2 bytes; with odd fetch_addr: 1 byte (fetch_data[15:8]) and the next fetch is even-aligned.
REQ-021 fetch_addr and fetch_req SHALL remain stable from entry to REQ/DISCARD until fetch_ack is sampled.
REQ-022 REQ with fetch_ack: write the delivered bytes, advance fetch_addr by their count (16-bit wrap 0xFFFF->0x0000), then go to IDLE.
REQ-023 fetch_ack SHALL be sampled only on ce_2 cycles; it is ignored in IDLE.
REQ-024 A consume_len > avail is illegal; the block SHALL ignore it, leaving pc and avail unchanged.
REQ-025 A legal consume SHALL advance the read pointer and pc by consume_len; pc wraps at 16 bits.
REQ-026 Write and consume in the same cycle: avail_next = avail + written - consume_len; consume is checked against pre-write avail.
REQ-027 window SHALL be combinational from the read pointer (byte i = buffer[(rd+i) mod DEPTH]); bytes at i >= avail are don't-care.
REQ-028 Flush SHALL take priority over consume and write: avail<=0, pointers<=0, pc<=flush_pc, fetch_addr<=flush_pc.
REQ-029 Flush state transitions: in REQ -> DISCARD; in IDLE or DISCARD -> IDLE (DISCARD keeps the old request outstanding).
REQ-030 DISCARD with fetch_ack: drop the data, keep fetch_addr at the flushed value, go to IDLE.
REQ-031 Flush with simultaneous fetch_ack in REQ: the data SHALL be dropped and the next state is IDLE.
REQ-032 Flush and all state updates SHALL take effect only when ce_1|ce_2.

Reset
REQ-033 On reset (independent of ce): state IDLE, pointers 0, avail 0, pc 0x0000, fetch_addr 0x0000, fetch_req 0.
REQ-034 Reset mid-request SHALL abandon the request; a fetch_ack arriving after reset while IDLE is ignored.

Verification
REQ-035 Reset, then flush_pc=0x0100, FETCH_BYTES=2, ack each request with 0x3412, 0x7856 -> fetch_addr 0x0100 then 0x0102; window[0..3]=12,34,56,78; avail=4.
REQ-036 flush_pc=0x0101 -> first fetch_addr 0x0101, only byte 0xAB of data 0xAB00 queued, next fetch_addr 0x0102; pc=0x0101.
REQ-037 Queue full (avail=8): fetch_req stays 0; consume_len=2 -> avail=6, pc+=2, then fetch_req=1 on the next enable.
REQ-038 Flush to 0x2000 while REQ pending at 0x0104; ack data 0xFFFF -> data dropped, avail=0; next request fetch_addr 0x2000.
REQ-039 avail=3, consume_len=3 with simultaneous 2-byte write -> avail=2; consume_len=5 with avail=3 -> ignored, pc unchanged.
REQ-040 pc=0xFFFE, fetches across the wrap boundary -> fetch_addr 0xFFFE then 0x0000; consume 4 -> pc=0x0002.

Source files
------------

// File: rtl/nec_fetch_queue.sv
// Instruction fetch queue: a circular byte buffer filled from a 1- or 2-byte
// bus and drained by the decoder through a WINDOW-byte view starting at pc.
//
// Fetch handshake: fetch_req is held high, with fetch_addr unchanged, from
// entry into REQ/DISCARD until fetch_ack is seen on a ce_2 cycle. The data
// is consumed on that same enabled edge and the request then drops for at
// least one enabled cycle (IDLE). A flush during an outstanding request keeps
// the request up (DISCARD) and drops whatever data answers it.
module nec_fetch_queue #(
    parameter int DEPTH       = 8,
    parameter int FETCH_BYTES = 2,
    parameter int WINDOW      = 6,
    localparam int AW = $clog2(DEPTH + 1),
    localparam int CW = $clog2(WINDOW + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_1,
    input  logic                     ce_2,
    input  logic                     flush,
    input  logic [15:0]              flush_pc,
    output logic                     fetch_req,
    output logic [15:0]              fetch_addr,
    input  logic                     fetch_ack,
    input  logic [8*FETCH_BYTES-1:0] fetch_data,
    input  logic [CW-1:0]            consume_len,
    output logic [WINDOW*8-1:0]      window,
    output logic [AW-1:0]            avail,
    output logic [15:0]              pc,
    output logic [1:0]               state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [15:0]   pc_q, pc_d, faddr_q, faddr_d;

    logic          en, ack_v, two_bytes, wr_en, cons_ok;
    logic [1:0]    nbytes, nwr;
    logic [CW-1:0] ncon;
    logic [15:0]   fd16;
    logic [7:0]    byte0, byte1;

    // Decode the bus beat: an odd address on a 2-byte bus only yields the high lane.
    always_comb begin
        en        = ce_1 | ce_2;
        ack_v     = ce_2 & fetch_ack;
        fd16      = 16'(fetch_data);
        two_bytes = (FETCH_BYTES == 2) && !faddr_q[0];
        nbytes    = two_bytes ? 2'd2 : 2'd1;
        byte0     = ((FETCH_BYTES == 2) && faddr_q[0]) ? fd16[15:8] : fd16[7:0];
        byte1     = fd16[15:8];
        cons_ok   = int'(consume_len) <= int'(cnt_q);
    end

    // Next-state logic: flush overrides everything, otherwise fetch FSM plus consume.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        wr_en   = 1'b0;
        nwr     = 2'd0;
        ncon    = '0;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
            pc_d    = flush_pc;
            faddr_d = flush_pc;
            state_d = (state_q == REQ && !ack_v) ? DISCARD : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if ((int'(cnt_q) + int'(nbytes)) <= DEPTH) state_d = REQ;
                end
                REQ: begin
                    if (ack_v) begin
                        wr_en   = 1'b1;
                        wr_d    = wr_q + PW'(nbytes);
                        faddr_d = faddr_q + 16'(nbytes);
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (ack_v) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            nwr   = wr_en ? nbytes : 2'd0;
            ncon  = cons_ok ? consume_len : '0;
            rd_d  = rd_q + PW'(ncon);
            cnt_d = cnt_q + AW'(nwr) - AW'(ncon);
            pc_d  = pc_q + 16'(ncon);
        end
    end

    // Control registers: reset is unconditional, everything else waits for an enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            pc_q    <= 16'h0000;
            faddr_q <= 16'h0000;
        end else if (en) begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
        end
    end

    // Byte storage: contents need no reset since avail gates their validity.
    always_ff @(posedge clk) begin
        if (!reset && en && wr_en) begin
            buf_q[wr_q] <= byte0;
            if (two_bytes) buf_q[wr_q + PW'(1)] <= byte1;
        end
    end

    // Decoder window: rotate the buffer so byte 0 sits at the read pointer.
    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW; i++) begin
            window[8*i +: 8] = buf_q[rd_q + PW'(i)];
        end
    end

    assign fetch_req   = (state_q == REQ) || (state_q == DISCARD);
    assign fetch_addr  = faddr_q;
    assign avail       = cnt_q;
    assign pc          = pc_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_nec_fetch_queue.sv
// Bench for nec_fetch_queue: directed scenarios then random traffic, all
// checked against a byte-queue model of the fetch queue.
module tb_nec_fetch_queue;

    localparam int DEPTH = 8;
    localparam int FB    = 2;
    localparam int WIN   = 6;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(WIN + 1);

    logic              clk = 1'b0;
    logic              reset, ce_1, ce_2, flush, fetch_ack;
    logic [15:0]       flush_pc;
    logic [8*FB-1:0]   fetch_data;
    logic [CW-1:0]     consume_len;
    logic              fetch_req;
    logic [15:0]       fetch_addr, pc;
    logic [WIN*8-1:0]  window;
    logic [AW-1:0]     avail;
    logic [1:0]        state_dbg_o;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: queued bytes, decode pc, next fetch address, request status
    logic [7:0]  mq[$];
    logic [15:0] m_pc, m_fa;
    bit          m_req, m_stale;

    nec_fetch_queue #(.DEPTH(DEPTH), .FETCH_BYTES(FB), .WINDOW(WIN)) dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2), .flush(flush),
        .flush_pc(flush_pc), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data), .consume_len(consume_len),
        .window(window), .avail(avail), .pc(pc), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("fetch_req", 32'(fetch_req), 32'(m_req));
        chk("fetch_addr", 32'(fetch_addr), 32'(m_fa));
        chk("avail", 32'(avail), 32'(mq.size()));
        chk("pc", 32'(pc), 32'(m_pc));
        for (int i = 0; i < WIN && i < mq.size(); i++)
            chk($sformatf("window[%0d]", i), 32'(window[8*i +: 8]), 32'(mq[i]));
    endtask

    // Behavioural rules: a request opens when the next beat fits, an ack fills
    // the queue unless a flush made it stale, consume pops from the front.
    task automatic model_step(input bit c1, input bit c2, input bit fl, input logic [15:0] fpc,
                              input bit ak, input logic [15:0] d, input int cl);
        int n, pre;
        bit ackv;
        if (!(c1 | c2)) return;
        ackv = c2 & ak;
        n    = m_fa[0] ? 1 : 2;
        pre  = mq.size();
        if (fl) begin
            mq.delete();
            m_pc = fpc;
            m_fa = fpc;
            if (m_req && !m_stale && !ackv) m_stale = 1;
            else begin m_req = 0; m_stale = 0; end
            return;
        end
        if (!m_req) begin
            if (DEPTH - pre >= n) m_req = 1;
        end else if (ackv) begin
            if (!m_stale) begin
                if (n == 2) begin mq.push_back(d[7:0]); mq.push_back(d[15:8]); end
                else mq.push_back(d[15:8]);
                m_fa = m_fa + 16'(n);
            end
            m_req = 0;
            m_stale = 0;
        end
        if (cl <= pre) begin
            repeat (cl) void'(mq.pop_front());
            m_pc = m_pc + 16'(cl);
        end
    endtask

    task automatic cyc_ce(input bit c1, input bit c2, input bit fl, input logic [15:0] fpc,
                          input bit ak, input logic [15:0] d, input int cl);
        @(negedge clk);
        ce_1 = c1; ce_2 = c2; flush = fl; flush_pc = fpc;
        fetch_ack = ak; fetch_data = d; consume_len = CW'(cl);
        model_step(c1, c2, fl, fpc, ak, d, cl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cyc(input bit fl, input logic [15:0] fpc, input bit ak,
                       input logic [15:0] d, input int cl);
        cyc_ce(1'b1, 1'b1, fl, fpc, ak, d, cl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; ce_1 = 0; ce_2 = 0; flush = 0; fetch_ack = 0; consume_len = '0;
        mq.delete(); m_pc = 16'h0000; m_fa = 16'h0000; m_req = 0; m_stale = 0;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(fetch_req), 32'h0);
        chk("rst_avail", 32'(avail), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_faddr", 32'(fetch_addr), 32'h0);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset = 1; ce_1 = 0; ce_2 = 0; flush = 0; flush_pc = '0;
        fetch_ack = 0; fetch_data = '0; consume_len = '0;
        do_reset();

        // two aligned fetches from 0x0100
        cyc(1, 16'h0100, 0, 16'h0, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s1_addr0", 32'(fetch_addr), 32'h0100);
        cyc(0, 16'h0, 1, 16'h3412, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s1_addr1", 32'(fetch_addr), 32'h0102);
        cyc(0, 16'h0, 1, 16'h7856, 0);
        chk("s1_win", 32'(window[31:0]), 32'h78563412);
        chk("s1_avail", 32'(avail), 32'd4);

        // fill to full, request must stay low until room appears
        cyc(0, 16'h0, 0, 16'h0, 0);
        cyc(0, 16'h0, 1, 16'hBC9A, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        cyc(0, 16'h0, 1, 16'hF0DE, 0);
        chk("s2_full", 32'(avail), 32'd8);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s2_noreq", 32'(fetch_req), 32'h0);
        cyc(0, 16'h0, 0, 16'h0, 2);
        chk("s2_avail", 32'(avail), 32'd6);
        chk("s2_pc", 32'(pc), 32'h0102);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s2_req", 32'(fetch_req), 32'h1);

        // clock enables low: flush must not take effect; ack on ce_1 only is ignored
        cyc_ce(0, 0, 1, 16'h5555, 1, 16'h1111, 0);
        cyc_ce(1, 0, 0, 16'h0, 1, 16'h1111, 0);
        chk("s3_hold", 32'(fetch_req), 32'h1);

        // flush during an outstanding request drops its data
        cyc(1, 16'h2000, 0, 16'h0, 0);
        chk("s4_disc_req", 32'(fetch_req), 32'h1);
        cyc(0, 16'h0, 1, 16'hFFFF, 0);
        chk("s4_avail", 32'(avail), 32'd0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s4_addr", 32'(fetch_addr), 32'h2000);

        // odd start, then illegal and simultaneous consume
        cyc(1, 16'h0101, 1, 16'h0, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s5_addr", 32'(fetch_addr), 32'h0101);
        cyc(0, 16'h0, 1, 16'hAB00, 0);
        chk("s5_byte", 32'(window[7:0]), 32'hAB);
        chk("s5_avail", 32'(avail), 32'd1);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s5_next", 32'(fetch_addr), 32'h0102);
        cyc(0, 16'h0, 1, 16'h2211, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        cyc(0, 16'h0, 0, 16'h0, 5);
        chk("s5_ill_pc", 32'(pc), 32'h0101);
        chk("s5_ill_av", 32'(avail), 32'd3);
        cyc(0, 16'h0, 1, 16'h4433, 3);
        chk("s5_mix_av", 32'(avail), 32'd2);
        chk("s5_mix_w", 32'(window[15:0]), 32'h4433);

        // address wrap
        cyc(1, 16'hFFFE, 0, 16'h0, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        cyc(0, 16'h0, 1, 16'hBBAA, 0);
        cyc(0, 16'h0, 0, 16'h0, 0);
        chk("s6_wrap", 32'(fetch_addr), 32'h0000);
        cyc(0, 16'h0, 1, 16'hDDCC, 0);
        cyc(0, 16'h0, 0, 16'h0, 4);
        chk("s6_pc", 32'(pc), 32'h0002);

        // reset mid-request, then a late ack while idle
        cyc(0, 16'h0, 0, 16'h0, 0);
        do_reset();
        cyc(0, 16'h0, 1, 16'h9999, 0);
        chk("s7_empty", 32'(avail), 32'd0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            int lim, cl;
            lim = (mq.size() > WIN) ? WIN : mq.size();
            cl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, lim);
            cyc_ce($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 39) == 0, 16'($urandom),
                   $urandom_range(0, 1) == 1, 16'($urandom), cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
